// File: rtl/fx_reverb_mem_if.sv
// Delay-RAM bus between the reverb tap scheduler and its sample memory.
// mem_rdata is valid one cycle after a cycle with mem_rd asserted.
interface fx_reverb_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wr,
        output mem_wdata,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wr,
        input  mem_wdata,
        input  mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/fx_reverb_sched.sv
// Reverb delay-line scheduler: one write then four tap reads per sample.
// Define REVERB_SCHED_OVERRUN_EN to build the sticky overrun detector.
module fx_reverb_sched #(
    parameter int DATA_W   = 16,
    parameter int PARAM_W  = 7,
    parameter int ADDR_W   = 14,
    parameter int NUM_TAPS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic [PARAM_W-1:0] size,
    fx_reverb_mem_if.master    mem,
    output logic               tap_valid,
    output logic [1:0]         tap_idx,
    output logic [DATA_W-1:0]  tap_data,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [1:0] LAST_TAP = 2'(NUM_TAPS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  wptr_q;
    logic [1:0]         tap_q;
    logic [DATA_W-1:0]  smp_q;
    logic [PARAM_W-1:0] size_q;
    logic               tap_valid_q;
    logic [1:0]         tap_idx_q;

    logic [5:0]         mult_k;
    logic [ADDR_W-1:0]  delay_t;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  addr_c;
    logic               wr_c;
    logic               rd_c;
    logic [DATA_W-1:0]  wdata_c;

    // Tap delay multipliers, scaled by (size+1).
    always_comb begin
        mult_k = 6'd29;
        unique case (tap_q)
            2'd0: mult_k = 6'd29;
            2'd1: mult_k = 6'd37;
            2'd2: mult_k = 6'd43;
            2'd3: mult_k = 6'd53;
            default: mult_k = 6'd29;
        endcase
    end

    assign delay_t = ADDR_W'((32'(size_q) + 32'd1) * 32'(mult_k));
    assign rd_addr = wptr_q - delay_t;

    always_comb begin
        state_d = state_q;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (sample_valid) state_d = WRITE;
            end
            WRITE: begin
                wr_c    = 1'b1;
                addr_c  = wptr_q;
                wdata_c = smp_q;
                state_d = READ;
            end
            READ: begin
                rd_c   = 1'b1;
                addr_c = rd_addr;
                if (tap_q == LAST_TAP) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            tap_q       <= '0;
            smp_q       <= '0;
            size_q      <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            tap_valid_q <= rd_c;
            tap_idx_q   <= tap_q;
            if (state_q == IDLE && sample_valid) begin
                smp_q  <= sample_in;
                size_q <= size;
                tap_q  <= '0;
            end
            if (state_q == READ) tap_q <= tap_q + 2'd1;
            if (state_q == DRAIN) wptr_q <= wptr_q + 1'b1;
        end
    end

    assign mem.mem_addr  = addr_c;
    assign mem.mem_wr    = wr_c;
    assign mem.mem_wdata = wdata_c;
    assign mem.mem_rd    = rd_c;

    assign tap_valid  = tap_valid_q;
    assign tap_idx    = tap_idx_q;
    assign tap_data   = mem.mem_rdata;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DRAIN);

`ifdef REVERB_SCHED_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_q <= 1'b0;
        else if (sample_valid && busy) ovr_q <= 1'b1;
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_fx_reverb_sched.sv
// Bench for fx_reverb_sched: random frames against a delay-line model.
// A narrow-address instance makes the write-pointer wrap reachable.
module tb_fx_reverb_sched;
    localparam int N_MAIN  = 16384;
    localparam int N_SMALL = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic [6:0]  size;
    logic        tap_valid;
    logic [1:0]  tap_idx;
    logic [15:0] tap_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    logic        sv2;
    logic [15:0] sin2;
    logic [6:0]  size2;
    logic        tv2;
    logic [1:0]  ti2;
    logic [15:0] td2;
    logic        busy2;
    logic        fd2;
    logic        ovr2;

    int n_vec = 0;
    int n_err = 0;
    int m_wptr = 0;

    bit   [15:0] ram [N_MAIN];
    bit   [15:0] mdl [N_MAIN];
    logic [15:0] rdata_q = '0;

    fx_reverb_mem_if #(.DATA_W(16), .ADDR_W(14)) m_if ();
    fx_reverb_mem_if #(.DATA_W(16), .ADDR_W(8))  s_if ();

    fx_reverb_sched #(.ADDR_W(14)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .size         (size),
        .mem          (m_if.master),
        .tap_valid    (tap_valid),
        .tap_idx      (tap_idx),
        .tap_data     (tap_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    fx_reverb_sched #(.ADDR_W(8)) u_small (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sv2),
        .sample_in    (sin2),
        .size         (size2),
        .mem          (s_if.master),
        .tap_valid    (tv2),
        .tap_idx      (ti2),
        .tap_data     (td2),
        .busy         (busy2),
        .frame_done   (fd2),
        .overrun      (ovr2)
    );

    always #5 clk = ~clk;

    // Sample RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (m_if.mem_wr) ram[m_if.mem_addr] <= m_if.mem_wdata;
        if (m_if.mem_rd) rdata_q <= ram[m_if.mem_addr];
    end
    assign m_if.mem_rdata = rdata_q;
    assign s_if.mem_rdata = '0;

    function automatic int exp_addr(int wp, int sz, int t, int n);
        int m [4] = '{29, 37, 43, 53};
        int d;
        d = (sz + 1) * m[t];
        return ((wp - d) % n + n) % n;
    endfunction

    // One frame from an idle cycle; mid asserts a stray strobe at cycle 3.
    task automatic frame(input logic [15:0] s, input logic [6:0] sz,
                         input bit mid);
        int         ra [4];
        logic [6:0] exp_ctl;
        logic [6:0] got_ctl;
        logic [1:0] ti;
        @(negedge clk);
        n_vec++;
        got_ctl = {m_if.mem_wr, m_if.mem_rd, tap_valid, tap_idx,
                   frame_done, busy};
        if (got_ctl !== 7'b0) begin
            n_err++;
            $display("FAIL idle_ctl got %b want %b", got_ctl, 7'b0);
        end
        sample_valid = 1'b1;
        sample_in    = s;
        size         = sz;
        for (int t = 0; t < 4; t++) ra[t] = exp_addr(m_wptr, sz, t, N_MAIN);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ti = (c >= 3) ? 2'(c - 3) : 2'd0;
            exp_ctl = {c == 1, (c >= 2 && c <= 5), c >= 3, ti,
                       c == 6, 1'b1};
            got_ctl = {m_if.mem_wr, m_if.mem_rd, tap_valid, tap_idx,
                       frame_done, busy};
            n_vec++;
            if (got_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL ctl c%0d got %b want %b", c, got_ctl, exp_ctl);
            end
            if (c == 1) begin
                n_vec++;
                if (m_if.mem_addr !== 14'(m_wptr) || m_if.mem_wdata !== s) begin
                    n_err++;
                    $display("FAIL wr got %0d/%h want %0d/%h", m_if.mem_addr,
                             m_if.mem_wdata, m_wptr, s);
                end
                mdl[m_wptr] = s;
            end
            if (c >= 2 && c <= 5) begin
                n_vec++;
                if (m_if.mem_addr !== 14'(ra[c-2])) begin
                    n_err++;
                    $display("FAIL rd_addr t%0d got %0d want %0d", c - 2,
                             m_if.mem_addr, ra[c-2]);
                end
            end
            if (c >= 3) begin
                n_vec++;
                if (tap_data !== mdl[ra[c-3]]) begin
                    n_err++;
                    $display("FAIL tap_data t%0d got %h want %h", c - 3,
                             tap_data, mdl[ra[c-3]]);
                end
            end
            sample_valid = mid && (c == 3);
            sample_in    = 16'($urandom);
            size         = 7'($urandom);
        end
        m_wptr = (m_wptr + 1) % N_MAIN;
    endtask

    task automatic test_reset;
        #3;
        n_vec++;
        if ({m_if.mem_wr, m_if.mem_rd, m_if.mem_addr, m_if.mem_wdata,
             tap_valid, tap_idx, busy, frame_done, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outs got %b want 0", {m_if.mem_wr,
                     m_if.mem_rd, m_if.mem_addr, m_if.mem_wdata, tap_valid,
                     tap_idx, busy, frame_done, overrun});
        end
        n_vec++;
        if (tap_data !== rdata_q) begin
            n_err++;
            $display("FAIL reset_tap_data got %h want %h", tap_data, rdata_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        n_vec++;
        if (exp_addr(0, 0, 3, N_MAIN) != 16331) begin
            n_err++;
            $display("FAIL model_addr got %0d want 16331",
                     exp_addr(0, 0, 3, N_MAIN));
        end
        frame(16'h1234, 7'd0, 1'b0);
    endtask

    task automatic test_random;
        while (m_wptr != 5000) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            frame(16'($urandom), 7'($urandom), 1'b0);
        end
    endtask

    task automatic test_size_max;
        n_vec++;
        if (exp_addr(m_wptr, 127, 2, N_MAIN) != 15880) begin
            n_err++;
            $display("FAIL size_max_addr got %0d want 15880",
                     exp_addr(m_wptr, 127, 2, N_MAIN));
        end
        frame(16'($urandom), 7'd127, 1'b0);
    endtask

    task automatic test_overrun;
        logic exp_ovr;
`ifdef REVERB_SCHED_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_pre got %b want 0", overrun);
        end
        frame(16'hbeef, 7'd9, 1'b1);
        @(negedge clk);
        n_vec++;
        if ({busy, m_if.mem_wr, overrun} !== {2'b00, exp_ovr}) begin
            n_err++;
            $display("FAIL overrun got %b want %b", {busy, m_if.mem_wr,
                     overrun}, {2'b00, exp_ovr});
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 16'h5a5a;
        size         = 7'd3;
        @(negedge clk);
        sample_valid = 1'b0;
        mdl[m_wptr]  = 16'h5a5a;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({m_if.mem_wr, m_if.mem_rd, m_if.mem_addr, m_if.mem_wdata,
             tap_valid, tap_idx, busy, frame_done, overrun} !== '0) begin
            n_err++;
            $display("FAIL midrst_outs got %b want 0", {m_if.mem_wr,
                     m_if.mem_rd, m_if.mem_addr, m_if.mem_wdata, tap_valid,
                     tap_idx, busy, frame_done, overrun});
        end
        @(negedge clk);
        reset  = 1'b0;
        m_wptr = 0;
        repeat (8) begin
            @(negedge clk);
            n_vec++;
            if ({frame_done, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL midrst_resume got %b want 00",
                         {frame_done, busy});
            end
        end
        frame(16'($urandom), 7'($urandom), 1'b0);
    endtask

    task automatic test_wrap;
        for (int f = 0; f <= N_SMALL; f++) begin
            @(negedge clk);
            sv2  = 1'b1;
            sin2 = 16'(f);
            @(negedge clk);
            sv2 = 1'b0;
            n_vec++;
            if (s_if.mem_wr !== 1'b1 || s_if.mem_addr !== 8'(f % N_SMALL)) begin
                n_err++;
                $display("FAIL wrap_wr f%0d got %b/%0d want 1/%0d", f,
                         s_if.mem_wr, s_if.mem_addr, f % N_SMALL);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        size         = '0;
        sv2          = 1'b0;
        sin2         = '0;
        size2        = 7'd5;
        test_reset;
        test_basic;
        test_random;
        test_size_max;
        test_overrun;
        test_mid_reset;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fx_reverb_sched.md
FX_REVERB_SCHED -- requirements
Module: fx_reverb_sched

Interface
REQ-001 Parameter: DATA_W, 16, audio sample width.
REQ-002 Parameter: PARAM_W, 7, control parameter width.
REQ-003 Parameter: ADDR_W, 14, delay RAM address width.
REQ-004 Parameter: NUM_TAPS, 4, reverb taps read per sample, fixed at 4.
REQ-005 Port: clk  in  1  single clock; all logic on rising edge.
REQ-006 Port: reset  in  1  reset, asynchronous, active-high.
REQ-007 Port: sample_valid  in  1  one-cycle strobe, new input sample present.
REQ-008 Port: sample_in  in  DATA_W  mono sample to write into the delay line.
REQ-009 Port: size  in  PARAM_W  room size, scales tap delays.
REQ-010 Port: mem_addr  out  ADDR_W  delay RAM address.
REQ-011 Port: mem_wr  out  1  RAM write enable.
REQ-012 Port: mem_wdata  out  DATA_W  RAM write data.
REQ-013 Port: mem_rd  out  1  RAM read enable; mem_rdata valid exactly 1 cycle later.
REQ-014 Port: mem_rdata  in  DATA_W  RAM read data.
REQ-015 Port: tap_valid  out  1  tap_data valid this cycle.
REQ-016 Port: tap_idx  out  2  tap number of tap_data.
REQ-017 Port: tap_data  out  DATA_W  tap sample; combinational copy of mem_rdata.
REQ-018 Port: busy  out  1  frame in progress.
REQ-019 Port: frame_done  out  1  one-cycle pulse at end of frame.
REQ-020 Port: overrun  out  1  sticky flag, sample_valid arrived while busy.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE, READ, DRAIN. busy = 1 in every state except IDLE.
REQ-022 In IDLE, on sample_valid=1: latch sample_in and size, clear tap counter, and go to WRITE.
REQ-023 In WRITE (one cycle): mem_wr=1, mem_addr=wptr, mem_wdata=latched sample. Then go to READ.
REQ-024 In READ: for tap t=0..3, one per cycle, mem_rd=1 and mem_addr=(wptr - D_t) mod 2^ADDR_W. After t=3, go to DRAIN.
REQ-025 Delay for tap t: D_t = (size_latched+1)*M_t, with M = {29,37,43,53}. Maximum value is 6784, which fits ADDR_W without saturation.
REQ-026 tap_valid and tap_idx SHALL be the registered mem_rd and tap counter, i.e. asserted 1 cycle after each read.
REQ-027 In DRAIN (one cycle): tap_valid=1 with tap_idx=3, frame_done=1, then wptr <= wptr+1 (wraps 2^ADDR_W-1 -> 0), then go to IDLE.
REQ-028 Timeline from strobe at cycle 0: WRITE cycle 1; reads cycles 2-5; taps cycles 3-6; frame_done cycle 6; next strobe accepted from cycle 7.
REQ-029 sample_valid while busy=1 SHALL be ignored: no state, latch or wptr change.
REQ-030 Changes to size or sample_in mid-frame SHALL have no effect on the current frame.
REQ-031 mem_wr and mem_rd SHALL never be asserted in the same cycle. Both SHALL be 0 in IDLE and DRAIN.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, wptr=0, tap counter=0, latches=0, and all outputs 0 (tap_data still follows mem_rdata).
REQ-033 Reset mid-frame SHALL abort the frame without frame_done. The frame does not resume after reset release.

Configuration
REQ-034 Macro REVERB_SCHED_OVERRUN_EN defined: overrun SHALL set on any sample_valid while busy=1 and hold until reset.
REQ-035 Macro REVERB_SCHED_OVERRUN_EN undefined: overrun SHALL be constant 0 and no detection logic is built. All other behaviour is identical.

Verification
REQ-036 Reset, size=0, strobe sample_in=0x1234 -> write addr 0 data 0x1234; reads at 16355, 16347, 16341, 16331; frame_done at cycle 6.
REQ-037 size=127 with wptr=5000 -> read addrs 1288, 264, 15880, 14600; tap_idx 0..3 on consecutive cycles.
REQ-038 Run 16384 frames from wptr=0 -> wptr wraps to 0; next write addr is 0.
REQ-039 Strobe at cycle 0 and again at cycle 3 -> second strobe dropped, one write only, overrun=1 (macro on) or 0 (macro off).
REQ-040 Assert reset at cycle 4 of a frame -> outputs 0 immediately, no frame_done; after release, a strobe writes at addr 0.
